// File: rtl/prime_scan_pkg.sv
// rtl/prime_scan_pkg.sv - shared state encodings and default widths for the prime scan buffer
package prime_scan_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_SRC_DEPTH = 16;
    localparam int DEF_BUF_DEPTH = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_TEST,
        S_STORE,
        S_NEXT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_CHECK,
        T_DIV
    } tst_state_t;

endpackage

// File: rtl/prime_test_seq.sv
// rtl/prime_test_seq.sv - sequential trial-division primality test with restoring remainder
module prime_test_seq
    import prime_scan_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [DATA_W-1:0] num,
    output logic              done,
    output logic              is_prime
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] TWO   = DATA_W'(2);
    localparam logic [DATA_W-1:0] THREE = DATA_W'(3);

    tst_state_t        st;
    logic [DATA_W-1:0] n_r;
    logic [DATA_W-1:0] d_r;
    logic [DATA_W-1:0] shf_r;
    logic [DATA_W-1:0] rem_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   rem_next;
    logic [2*DATA_W-1:0] d_sq;
    logic [2*DATA_W-1:0] n_ext;

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        trial    = {rem_r, shf_r[DATA_W-1]};
        rem_next = trial[DATA_W-1:0];
        if (trial >= {1'b0, d_r}) begin
            rem_next = DATA_W'(trial - {1'b0, d_r});
        end
        d_sq  = {{DATA_W{1'b0}}, d_r} * {{DATA_W{1'b0}}, d_r};
        n_ext = {{DATA_W{1'b0}}, n_r};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            st       <= T_IDLE;
            done     <= 1'b0;
            is_prime <= 1'b0;
            n_r      <= '0;
            d_r      <= '0;
            shf_r    <= '0;
            rem_r    <= '0;
            cnt_r    <= '0;
        end else begin
            done <= 1'b0;
            case (st)
                T_IDLE: begin
                    if (start) begin
                        n_r <= num;
                        if (num < TWO) begin
                            done     <= 1'b1;
                            is_prime <= 1'b0;
                        end else if (num <= THREE) begin
                            done     <= 1'b1;
                            is_prime <= 1'b1;
                        end else if (!num[0]) begin
                            done     <= 1'b1;
                            is_prime <= 1'b0;
                        end else begin
                            d_r <= THREE;
                            st  <= T_CHECK;
                        end
                    end
                end
                T_CHECK: begin
                    if (d_sq > n_ext) begin
                        done     <= 1'b1;
                        is_prime <= 1'b1;
                        st       <= T_IDLE;
                    end else begin
                        rem_r <= '0;
                        shf_r <= n_r;
                        cnt_r <= '0;
                        st    <= T_DIV;
                    end
                end
                T_DIV: begin
                    rem_r <= rem_next;
                    shf_r <= shf_r << 1;
                    cnt_r <= cnt_r + 1'b1;
                    // The last step decides directly so each divisor costs DATA_W+1 cycles.
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        if (rem_next == '0) begin
                            done     <= 1'b1;
                            is_prime <= 1'b0;
                            st       <= T_IDLE;
                        end else begin
                            d_r <= d_r + TWO;
                            st  <= T_CHECK;
                        end
                    end
                end
                default: st <= T_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/prime_scan_buffer.sv
// rtl/prime_scan_buffer.sv - scans a source ROM, keeps primes (or non-primes) in a readable buffer
module prime_scan_buffer
    import prime_scan_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SRC_DEPTH = DEF_SRC_DEPTH,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int SA_W      = $clog2(SRC_DEPTH),
    parameter int BA_W      = $clog2(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              go,
    input  logic              keep_np,
    output logic [SA_W-1:0]   src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic [BA_W-1:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [BA_W:0]     keep_cnt,
    output logic              overflow
);

    state_t            state;
    logic              keep_np_r;
    logic              keep_r;
    logic [DATA_W-1:0] num_r;
    logic              tst_start;
    logic              tst_done;
    logic              tst_is_prime;
    logic              full;
    logic              wr_en;

    logic [DATA_W-1:0] mem [BUF_DEPTH];

    assign full  = (keep_cnt == (BA_W+1)'(BUF_DEPTH));
    assign wr_en = (state == S_STORE) && keep_r && !full;

    prime_test_seq #(
        .DATA_W(DATA_W)
    ) u_test (
        .clk      (clk),
        .clr      (clr),
        .start    (tst_start),
        .num      (num_r),
        .done     (tst_done),
        .is_prime (tst_is_prime)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            src_addr  <= '0;
            keep_cnt  <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            keep_np_r <= 1'b0;
            keep_r    <= 1'b0;
            num_r     <= '0;
            tst_start <= 1'b0;
        end else begin
            tst_start <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        keep_np_r <= keep_np;
                        keep_cnt  <= '0;
                        overflow  <= 1'b0;
                        src_addr  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    num_r     <= src_data;
                    tst_start <= 1'b1;
                    state     <= S_TEST;
                end
                S_TEST: begin
                    if (tst_done) begin
                        keep_r <= tst_is_prime ^ keep_np_r;
                        state  <= S_STORE;
                    end
                end
                S_STORE: begin
                    if (keep_r) begin
                        if (!full) keep_cnt <= keep_cnt + 1'b1;
                        else       overflow <= 1'b1;
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (src_addr == SA_W'(SRC_DEPTH - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        src_addr <= src_addr + 1'b1;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Contents survive clr; only keep_cnt decides which entries are visible.
    always_ff @(posedge clk) begin
        if (wr_en) mem[keep_cnt[BA_W-1:0]] <= num_r;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < keep_cnt) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_prime_scan_buffer.sv
// tb/tb_prime_scan_buffer.sv - self-checking bench for prime_scan_buffer against a trial-division model
module tb_prime_scan_buffer;

    localparam int DW   = 8;
    localparam int SD   = 8;
    localparam int BD   = 4;
    localparam int SA_W = $clog2(SD);
    localparam int BA_W = $clog2(BD);

    logic            clk = 1'b0;
    logic            clr;
    logic            go;
    logic            keep_np;
    logic [SA_W-1:0] src_addr;
    logic [DW-1:0]   src_data;
    logic [BA_W-1:0] rd_addr;
    logic [DW-1:0]   rd_data;
    logic            busy;
    logic            done;
    logic [BA_W:0]   keep_cnt;
    logic            overflow;

    logic [DW-1:0] rom [SD];
    int vectors = 0;
    int errors  = 0;

    assign src_data = rom[src_addr];

    always #5 clk = ~clk;

    prime_scan_buffer #(
        .DATA_W(DW), .SRC_DEPTH(SD), .BUF_DEPTH(BD)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .go       (go),
        .keep_np  (keep_np),
        .src_addr (src_addr),
        .src_data (src_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .keep_cnt (keep_cnt),
        .overflow (overflow)
    );

    function automatic bit ref_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_rom(input int v0, v1, v2, v3, v4, v5, v6, v7);
        rom[0] = DW'(v0); rom[1] = DW'(v1); rom[2] = DW'(v2); rom[3] = DW'(v3);
        rom[4] = DW'(v4); rom[5] = DW'(v5); rom[6] = DW'(v6); rom[7] = DW'(v7);
    endtask

    task automatic pulse_go(input logic knp);
        @(negedge clk);
        go = 1'b1;
        keep_np = knp;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 4000 && !done; c++) @(negedge clk);
        check("done_timeout", done, 1);
    endtask

    // Full run: model picks kept words in address order; first BD of them land in the buffer.
    task automatic run_scan(input logic knp, input bit noisy_go);
        int kept[$];
        int exp_cnt;
        kept = {};
        for (int i = 0; i < SD; i++)
            if (ref_prime(int'(rom[i])) ^ knp) kept.push_back(int'(rom[i]));
        exp_cnt = (kept.size() > BD) ? BD : kept.size();

        pulse_go(knp);
        check("busy_after_go", busy, 1);
        check("done_after_go", done, 0);
        if (noisy_go) begin
            repeat (3) @(negedge clk);
            pulse_go(~knp);
            check("busy_ignores_go", busy, 1);
        end
        wait_done();
        check("busy_at_done", busy, 0);
        check("keep_cnt", keep_cnt, exp_cnt);
        check("overflow", overflow, kept.size() > BD);
        check("src_addr_hold", src_addr, SD - 1);
        for (int a = 0; a < BD; a++) begin
            rd_addr = BA_W'(a);
            @(negedge clk);
            check($sformatf("rd_data[%0d]", a), rd_data, (a < exp_cnt) ? kept[a] : 0);
        end
        repeat (3) @(negedge clk);
        check("done_sticky", done, 1);
    endtask

    initial begin
        clr = 1'b1; go = 1'b0; keep_np = 1'b0; rd_addr = '0;
        load_rom(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_keep_cnt", keep_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_src_addr", src_addr, 0);
        check("rst_rd_data", rd_data, 0);
        clr = 1'b0;

        load_rom(2, 4, 7, 9, 0, 1, 3, 255);
        run_scan(1'b0, 1'b0);
        run_scan(1'b1, 1'b0);

        load_rom(0, 1, 3, 255, 251, 2, 4, 6);
        run_scan(1'b0, 1'b0);

        load_rom(2, 3, 5, 7, 11, 13, 17, 19);
        run_scan(1'b0, 1'b0);
        load_rom(2, 4, 6, 8, 10, 12, 14, 15);
        run_scan(1'b0, 1'b1);

        // clr while the long 251 test is in progress at address 2.
        load_rom(3, 4, 251, 5, 8, 9, 13, 16);
        pulse_go(1'b0);
        for (int c = 0; c < 2000 && src_addr != SA_W'(2); c++) @(negedge clk);
        check("reach_addr2", src_addr, 2);
        repeat (8) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_keep_cnt", keep_cnt, 0);
        check("clr_src_addr", src_addr, 0);
        check("clr_done", done, 0);
        repeat (4) @(negedge clk);
        check("clr_stays_idle", busy, 0);
        run_scan(1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < SD; i++)
                rom[i] = (r < 3) ? DW'($urandom_range(0, 40)) : DW'($urandom_range(0, 255));
            run_scan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
